// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered RV32I-subset decoder between fetch and execute. Instruction words
// arrive over a valid/ready handshake, are decoded combinationally and captured
// into a two-entry buffer: a main register that drives the outputs and a skid
// register. The skid entry lets the stage take one more word in the same cycle
// that execute stalls, so throughput stays at one instruction per cycle.
// Unsupported encodings are passed downstream with out_illegal set. They are
// not dropped.
//
// Ports
//   clk            clock; all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   flush          synchronous discard of every held entry and of this cycle's input
//   in_valid       fetch presents an instruction
//   in_ready       stage can accept (registered)
//   in_instr       32-bit instruction word
//   in_pc          instruction address
//   out_valid      decoded bundle valid
//   out_ready      execute accepts the bundle
//   out_pc         passed-through PC
//   out_rd/rs1/rs2 register indices instr[11:7], [19:15], [24:20]
//   out_imm        sign-extended immediate
//   out_alu_ctrl   ADD 000, SUB 001, AND 010, OR 011, SLT 101
//   out_alu_src    1 = ALU operand B is the immediate
//   out_reg_write, out_mem_write, out_branch, out_jump  control strobes
//   out_result_src 00 ALU, 01 memory, 10 PC+4, 11 immediate
//   out_illegal    unsupported encoding
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [31:0]     out_imm,
  output logic [2:0]      out_alu_ctrl,
  output logic            out_alu_src,
  output logic            out_reg_write,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic [1:0]      out_result_src,
  output logic            out_illegal
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [2:0]      alu_ctrl;
    logic            alu_src;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;
  logic        legal;
  bundle_t     dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};

  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    dec.pc  = in_pc;
    dec.rd  = in_instr[11:7];
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];

    case (opcode)
      OP_REG: begin
        dec.reg_write  = 1'b1;
        dec.result_src = RES_ALU;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE) begin
              dec.alu_ctrl = ALU_ADD;
              legal        = 1'b1;
            end else if (funct7 == F7_ALT) begin
              dec.alu_ctrl = ALU_SUB;
              legal        = 1'b1;
            end
          end
          3'b010: begin
            dec.alu_ctrl = ALU_SLT;
            legal        = (funct7 == F7_BASE);
          end
          3'b110: begin
            dec.alu_ctrl = ALU_OR;
            legal        = (funct7 == F7_BASE);
          end
          3'b111: begin
            dec.alu_ctrl = ALU_AND;
            legal        = (funct7 == F7_BASE);
          end
          default: ;
        endcase
      end

      OP_IMM: begin
        dec.imm        = imm_i;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_ALU;
        case (funct3)
          3'b000: begin dec.alu_ctrl = ALU_ADD; legal = 1'b1; end
          3'b010: begin dec.alu_ctrl = ALU_SLT; legal = 1'b1; end
          3'b110: begin dec.alu_ctrl = ALU_OR;  legal = 1'b1; end
          3'b111: begin dec.alu_ctrl = ALU_AND; legal = 1'b1; end
          default: ;
        endcase
      end

      OP_LOAD: begin
        dec.alu_ctrl   = ALU_ADD;
        dec.imm        = imm_i;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_MEM;
        legal          = (funct3 == 3'b010);
      end

      OP_STORE: begin
        dec.alu_ctrl  = ALU_ADD;
        dec.imm       = imm_s;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        legal         = (funct3 == 3'b010);
      end

      OP_BRANCH: begin
        dec.alu_ctrl = ALU_SUB;
        dec.imm      = imm_b;
        dec.branch   = 1'b1;
        legal        = (funct3 == 3'b000);
      end

      OP_JAL: begin
        dec.imm        = imm_j;
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        legal          = 1'b1;
      end

      OP_LUI: begin
        dec.imm        = imm_u;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_IMM;
        legal          = 1'b1;
      end

      default: ;
    endcase

    // An unsupported word must not have side effects downstream. The
    // pass-through fields are kept so the trap handler can report them.
    if (!legal) begin
      dec.illegal   = 1'b1;
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.alu_ctrl  = ALU_ADD;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry buffer control
  // ---------------------------------------------------------------------------
  state_t  state_q, state_d;
  logic    in_ready_q;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    accept;
  logic    xfer;
  logic    load_main;
  logic    load_skid;
  logic    skid_to_main;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && out_ready) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = ST_TWO;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so nothing new can arrive this cycle
        if (out_ready) begin
          skid_to_main = 1'b1;
          state_d      = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // A flush overrides everything, including a word accepted this cycle
    if (flush) begin
      state_d      = ST_EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  always_comb begin
    main_d = main_q;
    if (load_main) begin
      main_d = dec;
    end else if (skid_to_main) begin
      main_d = skid_q;
    end
  end

  always_comb begin
    skid_d = skid_q;
    if (load_skid) begin
      skid_d = dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign out_pc         = main_q.pc;
  assign out_rd         = main_q.rd;
  assign out_rs1        = main_q.rs1;
  assign out_rs2        = main_q.rs2;
  assign out_imm        = main_q.imm;
  assign out_alu_ctrl   = main_q.alu_ctrl;
  assign out_alu_src    = main_q.alu_src;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_write  = main_q.mem_write;
  assign out_branch     = main_q.branch;
  assign out_jump       = main_q.jump;
  assign out_result_src = main_q.result_src;
  assign out_illegal    = main_q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I-subset instruction decoder sitting between fetch and execute in the pipelined core. It consumes fetched instruction words over a valid/ready handshake and drives the decoded control bundle (ALU control, immediate, register indices, writeback/memory controls) to execute. Skid buffering keeps full throughput under backpressure. The block flags unsupported encodings rather than dropping them.

## Interface
- XLEN, 32, datapath width; only 32 supported
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all held entries (taken branch/jump)
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  decoder can accept; registered
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  XLEN  passed-through PC
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20]
- out_imm  out  32  sign-extended immediate
- out_alu_ctrl  out  3  ADD 000, SUB 001, AND 010, OR 011, SLT 101; 110/111 reserved, never driven
- out_alu_src  out  1  1 = ALU operand B from immediate
- out_reg_write, out_mem_write, out_branch, out_jump  out  1 each
- out_result_src  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate
- out_illegal  out  1  unsupported encoding

## Operation
- Decode (combinational on in_instr, captured on accept):
  - 0110011 R: f3=000,f7=0000000 ADD; f3=000,f7=0100000 SUB; f3=010 SLT; f3=110 OR; f3=111 AND (f7=0 required except SUB); reg_write 1, alu_src 0, result 00.
  - 0010011 I-ALU: f3 000/010/110/111 → ADD/SLT/OR/AND; I-imm; reg_write 1, alu_src 1, result 00.
  - 0000011 LOAD: f3=010 only; ADD, I-imm, alu_src 1, reg_write 1, result 01.
  - 0100011 STORE: f3=010 only; ADD, S-imm, alu_src 1, mem_write 1.
  - 1100011 BRANCH: f3=000 only; SUB, B-imm, branch 1.
  - 1101111 JAL: J-imm, jump 1, reg_write 1, result 10.
  - 0110111 LUI: U-imm (instr[31:12]<<12), reg_write 1, result 11.
  - Anything else: illegal 1; reg_write, mem_write, branch, jump forced 0; alu_ctrl 000; other fields still passed.
- Storage: main register (drives outputs) + one skid register. States:
  - EMPTY: out_valid 0. Accept → ONE.
  - ONE: accept & out_ready → ONE (main replaced); accept & !out_ready → TWO (new into skid); !accept & out_ready → EMPTY.
  - TWO: in_ready 0; out_ready → ONE (skid moves to main).
- Accept = in_valid & in_ready; output transfer = out_valid & out_ready.
- in_ready = (next state != TWO), registered.
- flush highest priority: next state EMPTY, input that cycle discarded even if accepted; in_ready 1 next cycle.

## Timing
- Reset: state EMPTY, out_valid 0, in_ready 1, all out_* fields 0 (alu_ctrl 000, result_src 00).
- Latency: instruction accepted at edge k appears with out_valid 1 after edge k.
- Throughput 1 instruction/cycle with out_ready held high; strict in-order, no loss, no duplication.
- Outputs stable while out_valid & !out_ready.
- Reset mid-operation: both entries discarded immediately, outputs to reset values.

## Test plan
- add x3,x1,x2 (0x002081B3) → alu_ctrl 000, reg_write 1, alu_src 0, rd 3, rs1 1, rs2 2, illegal 0.
- sub x5,x6,x7 (0x407302B3) → alu_ctrl 001, rd 5; sw x2,-4(x1) (0xFE20AE23) → imm 0xFFFFFFFC, mem_write 1, reg_write 0, alu_ctrl 000.
- lui x1,0x12345 (0x123450B7) → imm 0x12345000, result_src 11, reg_write 1.
- 0x00000000 and R-type f3=001 → illegal 1, reg_write/mem_write/branch/jump 0.
- out_ready low, push A then B → in_ready 0 after B accepted; raise out_ready → A then B on consecutive cycles, then EMPTY.
- In TWO, assert flush with in_valid 1 → out_valid 0 and in_ready 1 next cycle, nothing emitted; async reset pulse mid-stream → same.
